intpol2_d4_out_fifo: RTL and testbench
======================================

# intpol2_D4_out_fifo

Output sample buffer directly downstream of the intpol2_D4 datapath/controlpath pair. Accepts interpolated samples on the controlpath's write-enable strobe and presents them to the consumer over a valid/ready stream. Produces the almost-full flag the controlpath uses to stall (stop_Afull), and reports overflow and occupancy. First-word-fall-through, single clock.

## Interface

- DATA_WIDTH, 32, sample width; matches the datapath output.
- ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH = 16.
- AFULL_MARGIN, 4, free slots remaining when Afull_o asserts; must be ≥ the controlpath write-pipeline depth after Afull is sampled.

Ports:

- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- clear  in  1  synchronous flush from the controlpath clear; same effect as rst on this block.
- Write_Enable_i  in  1  push strobe from the controlpath.
- wr_data_i  in  DATA_WIDTH  sample to push.
- m_valid_o  out  1  head sample available.
- m_data_o  out  DATA_WIDTH  head sample; valid only while m_valid_o=1.
- m_ready_i  in  1  consumer accepts head; pop = m_valid_o & m_ready_i.
- Afull_o  out  1  level ≥ DEPTH − AFULL_MARGIN.
- full_o  out  1  level = DEPTH.
- Empty_o  out  1  level = 0.
- level_o  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow_o  out  1  sticky; a push was dropped.

## Operation

- Storage: DEPTH×DATA_WIDTH array; wr_ptr and rd_ptr are ADDR_WIDTH+1 bits, with the MSB as the wrap bit.
  - Empty: pointers are equal.
  - Full: low bits are equal and MSBs differ.
  - Pointers wrap modulo 2·DEPTH; no special case at the index DEPTH−1 → 0 transition.
- push = Write_Enable_i & (!full_o | pop). A write when full with a simultaneous pop is accepted.
- A write while full without a pop is dropped. It sets overflow_o, and memory and pointers stay unchanged.
- level updates each cycle:
  - push only: +1.
  - pop only: −1.
  - both: unchanged.
  - neither: unchanged.
- A pop while empty is impossible because m_valid_o gates it. m_ready_i with m_valid_o=0 has no effect.
- When empty, a write and m_ready_i in the same cycle: the write is stored and nothing is popped.
- m_valid_o = !Empty_o. m_data_o = mem[rd_ptr low bits] (combinational read of the registered array).
- Flags are decoded from the registered pointers/level.
- overflow_o clears only on rst or clear.
- rst/clear, including mid-stream: the next cycle has pointers 0, level 0 and overflow 0. Memory contents are not cleared.
  - clear has priority over a push or pop in the same cycle; that push/pop is discarded.

## Timing

- Reset values: m_valid_o=0, Empty_o=1, full_o=0, Afull_o=0, level_o=0, overflow_o=0, m_data_o=don't-care.
- Write-to-output latency: a push at edge N gives m_valid_o=1 and m_data_o equal to that sample after edge N (usable in cycle N+1).
- Pop at edge N: the next sample is presented in cycle N+1; back-to-back pops sustain 1 sample/cycle.
- Afull_o, full_o, Empty_o and level_o reflect state after the latest edge, with one-cycle visibility.
  - The controlpath sees Afull_o one cycle after the push that crosses the threshold, hence AFULL_MARGIN.
- No combinational path from m_ready_i or Write_Enable_i to any flag output.
- m_ready_i → pop affects only the next-state pointers.

## Structure

- Shared intpol2_D4 package/header holds:
  - DEPTH derivation from ADDR_WIDTH.
  - Default AFULL_MARGIN, tied to the controlpath pipeline depth constant.
  - Pointer-width constant ADDR_WIDTH+1.
- One natural sub-module: intpol2_D4_fifo_ptr, a parameterised wrap-bit pointer register with sync reset, clear and an increment enable, instantiated twice (write and read).
- The array, level counter, flag decode and overflow latch stay in the top.

## Test plan

- Reset/idle: assert rst 2 cycles → all outputs at reset values; push 0xA5A5_0001 → next cycle m_valid_o=1, m_data_o=0xA5A5_0001, level_o=1, Empty_o=0.
- Fill to threshold, m_ready_i=0: 11 pushes → Afull_o=0; 12th push → Afull_o=1 the following cycle with level_o=12; 16 pushes → full_o=1, level_o=16.
- Overflow: with full, push 0xDEAD_BEEF and m_ready_i=0 → overflow_o=1, level_o stays 16. Then drain 16 pops → data order is 0..15 and 0xDEAD_BEEF is never seen.
- Full with simultaneous push and pop: level_o stays 16, overflow_o stays 0, and the pushed word emerges 16th.
- Wrap and throughput: 40 samples with continuous push, m_ready_i=1 → output equals input in order at 1/cycle after 1-cycle latency; level_o ≤ 1; pointers wrap 2× without error.
- Mid-stream clear: at level 9 assert clear together with a push and a pop → next cycle level_o=0, Empty_o=1, m_valid_o=0, overflow_o=0; a subsequent push 0x1234 appears as the first output.

Source files
------------

// File: rtl/intpol2_d4_out_fifo_pkg.sv
// intpol2_d4_out_fifo_pkg
//   Constants shared by the intpol2_D4 output FIFO and its pointer sub-module.
//   - CTRL_PIPE_DEPTH      : number of writes the controlpath can still issue
//                            after it samples Afull_o.
//   - DEFAULT_AFULL_MARGIN : free slots left when Afull_o asserts; tied to the
//                            controlpath pipeline depth so no write is lost.
//   - depth_of()           : FIFO depth derived from the address width.
//   - ptr_width()          : pointer width (address bits plus one wrap bit).
package intpol2_d4_out_fifo_pkg;

    localparam int CTRL_PIPE_DEPTH      = 4;
    localparam int DEFAULT_AFULL_MARGIN = CTRL_PIPE_DEPTH;

    function automatic int depth_of(input int addr_width);
        return 1 << addr_width;
    endfunction

    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/intpol2_d4_fifo_ptr.sv
// intpol2_d4_fifo_ptr
//   Wrap-bit FIFO pointer register. The low PTR_WIDTH-1 bits index the
//   storage array; the MSB toggles on every pass through the array so that
//   equal pointers mean empty and equal-low/different-MSB pointers mean full.
//   The pointer counts modulo 2**PTR_WIDTH with no special wrap handling.
// Ports:
//   clk   in  clock, rising edge
//   rst   in  synchronous active-high reset, pointer -> 0
//   clear in  synchronous flush, same effect as rst
//   inc   in  advance pointer by one (ignored while rst/clear)
//   ptr   out registered pointer value
module intpol2_d4_fifo_ptr #(
    parameter int PTR_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 inc,
    output logic [PTR_WIDTH-1:0] ptr
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + PTR_WIDTH'(1);
        end
    end

endmodule

// File: rtl/intpol2_d4_out_fifo.sv
// intpol2_d4_out_fifo
//   First-word-fall-through output buffer behind the intpol2_D4 datapath.
//   Samples are pushed on the controlpath write strobe and presented to the
//   consumer on a valid/ready stream. Single clock domain.
//
//   Handshake: the head word transfers on a rising edge where
//   m_valid_o && m_ready_i. m_valid_o never depends on m_ready_i, m_data_o is
//   stable while m_valid_o is high and the word is not taken, and m_ready_i
//   while m_valid_o is low is ignored. The write side has no back-pressure:
//   the controlpath must honour Afull_o; a write while full with no pop in the
//   same cycle is dropped and latched in overflow_o.
//
// Ports:
//   clk            in  clock, rising edge
//   rst            in  synchronous active-high reset
//   clear          in  synchronous flush, same effect as rst
//   Write_Enable_i in  push strobe
//   wr_data_i      in  sample to push
//   m_valid_o      out head sample available
//   m_data_o       out head sample
//   m_ready_i      in  consumer takes the head
//   Afull_o        out level >= DEPTH - AFULL_MARGIN
//   full_o         out level == DEPTH
//   Empty_o        out level == 0
//   level_o        out occupancy 0..DEPTH
//   overflow_o     out sticky: a push was dropped
module intpol2_d4_out_fifo
    import intpol2_d4_out_fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 4,
    parameter int AFULL_MARGIN = DEFAULT_AFULL_MARGIN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  Write_Enable_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic                  m_valid_o,
    output logic [DATA_WIDTH-1:0] m_data_o,
    input  logic                  m_ready_i,
    output logic                  Afull_o,
    output logic                  full_o,
    output logic                  Empty_o,
    output logic [ADDR_WIDTH:0]   level_o,
    output logic                  overflow_o
);

    localparam int DEPTH = depth_of(ADDR_WIDTH);
    localparam int PTR_W = ptr_width(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      level_q;
    logic                  overflow_q;
    logic                  flush;
    logic                  push;
    logic                  pop;

    assign flush = rst || clear;

    // Flags come only from registered pointers/level, so neither m_ready_i
    // nor Write_Enable_i reaches any flag combinationally.
    assign Empty_o   = (wr_ptr == rd_ptr);
    assign full_o    = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                       (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
    assign Afull_o   = (level_q >= PTR_W'(DEPTH - AFULL_MARGIN));
    assign level_o   = level_q;
    assign m_valid_o = !Empty_o;
    assign m_data_o  = mem[rd_ptr[ADDR_WIDTH-1:0]];
    assign overflow_o = overflow_q;

    // A write while full is still accepted when the head leaves in the same
    // cycle, because the popped slot is the one being overwritten.
    assign pop  = m_valid_o && m_ready_i;
    assign push = Write_Enable_i && (!full_o || pop);

    intpol2_d4_fifo_ptr #(.PTR_WIDTH(PTR_W)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .inc   (push),
        .ptr   (wr_ptr)
    );

    intpol2_d4_fifo_ptr #(.PTR_WIDTH(PTR_W)) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .inc   (pop),
        .ptr   (rd_ptr)
    );

    // Storage is not reset; a flush only rewinds the pointers.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            level_q <= '0;
        end else begin
            case ({push, pop})
                2'b10:   level_q <= level_q + PTR_W'(1);
                2'b01:   level_q <= level_q - PTR_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            overflow_q <= 1'b0;
        end else if (Write_Enable_i && !push) begin
            overflow_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_intpol2_d4_out_fifo.sv
// tb_intpol2_d4_out_fifo
//   Directed bench for intpol2_d4_out_fifo. A queue holds the words the
//   FIFO should contain; each step compares the head/flags against it.
module tb_intpol2_d4_out_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int AFULL_LEVEL = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clear = 1'b0;
    logic          Write_Enable_i = 1'b0;
    logic [DW-1:0] wr_data_i = '0;
    logic          m_valid_o;
    logic [DW-1:0] m_data_o;
    logic          m_ready_i = 1'b0;
    logic          Afull_o;
    logic          full_o;
    logic          Empty_o;
    logic [4:0]    level_o;
    logic          overflow_o;

    logic [DW-1:0] exp_q[$];
    logic          model_ovf = 1'b0;
    int            checks = 0;
    int            failures = 0;

    intpol2_d4_out_fifo dut (
        .clk            (clk),
        .rst            (rst),
        .clear          (clear),
        .Write_Enable_i (Write_Enable_i),
        .wr_data_i      (wr_data_i),
        .m_valid_o      (m_valid_o),
        .m_data_o       (m_data_o),
        .m_ready_i      (m_ready_i),
        .Afull_o        (Afull_o),
        .full_o         (full_o),
        .Empty_o        (Empty_o),
        .level_o        (level_o),
        .overflow_o     (overflow_o)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- comparison ----------------
    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Flags against the model queue, sampled #1 after an edge.
    task automatic check_flags(input string tag);
        int n;
        n = exp_q.size();
        check({tag, ".level"},  level_o,    DW'(n));
        check({tag, ".empty"},  Empty_o,    DW'(n == 0));
        check({tag, ".valid"},  m_valid_o,  DW'(n != 0));
        check({tag, ".full"},   full_o,     DW'(n == DEPTH));
        check({tag, ".afull"},  Afull_o,    DW'(n >= AFULL_LEVEL));
        check({tag, ".ovf"},    overflow_o, DW'(model_ovf));
    endtask

    // ---------------- drivers ----------------
    // One clock of traffic: drive, compare the head if it is taken, update
    // the model, clock, then compare flags.
    task automatic step(input string tag, input logic we, input logic [DW-1:0] d,
                        input logic rdy, input logic flags);
        logic model_pop;
        Write_Enable_i = we;
        wr_data_i      = d;
        m_ready_i      = rdy;
        #1;
        model_pop = rdy && (exp_q.size() != 0);
        if (model_pop) begin
            check({tag, ".data"}, m_data_o, exp_q.pop_front());
        end
        if (we) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(d);
            else model_ovf = 1'b1;
        end
        @(posedge clk);
        #1;
        Write_Enable_i = 1'b0;
        m_ready_i      = 1'b0;
        if (flags) check_flags(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        Write_Enable_i = 1'b0;
        m_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        model_ovf = 1'b0;
    endtask

    task automatic do_clear(input logic we, input logic [DW-1:0] d, input logic rdy);
        clear = 1'b1;
        Write_Enable_i = we;
        wr_data_i = d;
        m_ready_i = rdy;
        @(posedge clk);
        #1;
        clear = 1'b0;
        Write_Enable_i = 1'b0;
        m_ready_i = 1'b0;
        exp_q.delete();
        model_ovf = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        @(posedge clk);
        #1;

        // Reset and idle
        do_reset();
        check_flags("reset");

        // Single push, head falls through next cycle
        step("push1", 1'b1, 32'hA5A5_0001, 1'b0, 1'b1);
        check("push1.head", m_data_o, 32'hA5A5_0001);
        step("pop1", 1'b0, '0, 1'b1, 1'b1);

        // Fill to threshold and full, no consumer
        for (int i = 0; i < DEPTH; i++) begin
            step("fill", 1'b1, DW'(i), 1'b0, 1'b1);
        end
        check("fill.full", full_o, 1);

        // Write while full is dropped
        step("ovf", 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
        check("ovf.sticky", overflow_o, 1);
        for (int i = 0; i < DEPTH; i++) begin
            step("drain", 1'b0, '0, 1'b1, 1'b1);
        end
        check("drain.empty", Empty_o, 1);

        // Flush clears the overflow latch
        do_clear(1'b0, '0, 1'b0);
        check_flags("clr_ovf");

        // Full with simultaneous push and pop
        for (int i = 0; i < DEPTH; i++) begin
            step("fill2", 1'b1, 32'h100 + DW'(i), 1'b0, 1'b0);
        end
        check_flags("fill2");
        step("pushpop", 1'b1, 32'hCAFE_F00D, 1'b1, 1'b1);
        for (int i = 0; i < DEPTH; i++) begin
            step("drain2", 1'b0, '0, 1'b1, 1'b1);
        end

        // Continuous stream with wrap
        for (int i = 0; i < 40; i++) begin
            step("stream", 1'b1, $urandom_range(32'hFFFF_FFFF, 0), 1'b1, 1'b1);
            checks++;
            assert (level_o <= 5'd1) else begin
                failures++;
                $error("FAIL stream.level_le1 observed=%0d expected<=1", level_o);
            end
        end
        step("stream_tail", 1'b0, '0, 1'b1, 1'b1);

        // Mid-stream clear with push and pop in the same cycle
        for (int i = 0; i < 9; i++) begin
            step("pre_clr", 1'b1, 32'h200 + DW'(i), 1'b0, 1'b0);
        end
        check("pre_clr.level", level_o, 9);
        do_clear(1'b1, 32'h0BAD_0BAD, 1'b1);
        check_flags("mid_clr");
        step("post_clr", 1'b1, 32'h0000_1234, 1'b0, 1'b1);
        check("post_clr.head", m_data_o, 32'h0000_1234);
        step("post_clr_pop", 1'b0, '0, 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
